// File: rtl/framer_pkg.sv
// Shared types and constants for the framing path.
//   FRAME_128 / FRAME_256 : the two supported frame sizes N
//   deframe_state_t       : deframer state machine encoding
//   sample_t              : 8-bit unsigned sample
package framer_pkg;

    localparam int unsigned FRAME_128 = 128;
    localparam int unsigned FRAME_256 = 256;

    typedef enum logic [2:0] {
        IDLE,
        PASS,
        ACCUM,
        STORE,
        FLUSH
    } deframe_state_t;

    typedef logic [7:0] sample_t;

endpackage

// File: rtl/overlap_add_deframer_if.sv
// Stream bundle for the deframer: frame input stream and sample output stream.
//   frame_valid/frame_ready/frame_data/frame_last : window samples in
//   sample_valid/sample_ready/sample_data         : rebuilt samples out
// slave modport is the deframer side, master modport is the surrounding system.
interface overlap_add_deframer_if;

    logic                frame_valid;
    logic                frame_ready;
    framer_pkg::sample_t frame_data;
    logic                frame_last;
    logic                sample_valid;
    logic                sample_ready;
    framer_pkg::sample_t sample_data;

    modport slave (
        input  frame_valid, frame_data, frame_last, sample_ready,
        output frame_ready, sample_valid, sample_data
    );

    modport master (
        output frame_valid, frame_data, frame_last, sample_ready,
        input  frame_ready, sample_valid, sample_data
    );

endinterface

// File: rtl/deframer_tail_ram.sv
// Overlap tail storage: Depth x 8 register array.
//   clk     : clock
//   we_i    : synchronous write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : combinational read address
//   rdata_o : read data
// Contents are not reset; the owner guards them with a valid flag.
module deframer_tail_ram
    import framer_pkg::*;
#(
    parameter int unsigned Depth = 128,
    localparam int unsigned Aw   = $clog2(Depth)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [Aw-1:0] waddr_i,
    input  sample_t       wdata_i,
    input  logic [Aw-1:0] raddr_i,
    output sample_t       rdata_o
);

    sample_t mem_q [Depth];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/overlap_add_deframer.sv
// Overlap-add deframer: rebuilds a continuous sample stream from window frames,
// either passing frames through or overlap-adding with a hop of N/2.
//   clk, reset            : clock, synchronous active-high reset
//   use_256_points_i      : frame size select (1: 256, 0: 128)
//   overlap_half_window_i : 1 = overlap-add, 0 = pass-through
//   flush_i               : pulse to emit the pending overlap tail
//   frame_error_o         : sticky framing error
//   busy_o                : state machine not idle
//   bus                   : frame input / sample output streams
// Build option DEFRAMER_SATURATE_EN: overlap sums clamp at 255 instead of wrapping.
module overlap_add_deframer
    import framer_pkg::*;
#(
    parameter int unsigned MAX_N = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    use_256_points_i,
    input  logic                    overlap_half_window_i,
    input  logic                    flush_i,
    output logic                    frame_error_o,
    output logic                    busy_o,
    overlap_add_deframer_if.slave   bus
);

    localparam int unsigned TailDepth = MAX_N / 2;
    localparam int unsigned Aw        = $clog2(TailDepth);

    deframe_state_t state_q, state_d, phase;
    logic [7:0]     idx_q, idx_d;
    logic           n256_q, n256_d;
    logic           ovl_q, ovl_d;
    logic           tail_valid_q, tail_valid_d;
    logic           flush_pend_q, flush_pend_d;
    logic           err_q, err_d;
    logic           sv_q, sv_d;
    sample_t        sd_q, sd_d;

    logic           frame_ready, fire, out_free, eff_n256, end_idx, tail_we;
    logic [7:0]     last_idx, half_m1;
    logic [Aw-1:0]  waddr;
    sample_t        tail_rd, acc_sum, acc;

    // In IDLE the incoming first sample decides the frame configuration.
    assign eff_n256 = (state_q == IDLE) ? use_256_points_i : n256_q;
    assign last_idx = eff_n256 ? 8'(FRAME_256 - 1) : 8'(FRAME_128 - 1);
    assign half_m1  = eff_n256 ? 8'(FRAME_256 / 2 - 1) : 8'(FRAME_128 / 2 - 1);
    assign end_idx  = (idx_q == last_idx);
    assign out_free = !sv_q || bus.sample_ready;
    assign fire     = bus.frame_valid && frame_ready;

    // STORE runs at idx N/2..N-1; dropping the half bit gives idx - N/2.
    always_comb begin
        waddr = idx_q[Aw-1:0];
        if (!n256_q) begin
            waddr[Aw-1] = 1'b0;
        end
    end

`ifdef DEFRAMER_SATURATE_EN
    logic [8:0] sum9;
    assign sum9    = {1'b0, bus.frame_data} + {1'b0, tail_rd};
    assign acc_sum = sum9[8] ? 8'hFF : sum9[7:0];
`else
    assign acc_sum = bus.frame_data + tail_rd;
`endif
    assign acc = tail_valid_q ? acc_sum : bus.frame_data;

    deframer_tail_ram #(
        .Depth (TailDepth)
    ) u_tail (
        .clk     (clk),
        .we_i    (tail_we),
        .waddr_i (waddr),
        .wdata_i (bus.frame_data),
        .raddr_i (idx_q[Aw-1:0]),
        .rdata_o (tail_rd)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        n256_d       = n256_q;
        ovl_d        = ovl_q;
        tail_valid_d = tail_valid_q;
        flush_pend_d = flush_pend_q | flush_i;
        err_d        = err_q;
        sv_d         = out_free ? 1'b0 : sv_q;
        sd_d         = sd_q;
        tail_we      = 1'b0;
        phase        = state_q;

        unique case (state_q)
            STORE:   frame_ready = 1'b1;
            FLUSH:   frame_ready = 1'b0;
            default: frame_ready = out_free;
        endcase

        if (state_q == IDLE) begin
            phase = overlap_half_window_i ? ACCUM : PASS;
            if (fire) begin
                // Frame wins over flush; a flush request stays pending.
                n256_d = use_256_points_i;
                ovl_d  = overlap_half_window_i;
                if (!overlap_half_window_i) begin
                    tail_valid_d = 1'b0;
                end
            end else if (flush_i || flush_pend_q) begin
                flush_pend_d = 1'b0;
                if (tail_valid_q) begin
                    state_d = FLUSH;
                end
            end
        end

        if (fire) begin
            unique case (phase)
                PASS: begin
                    sv_d = 1'b1;
                    sd_d = bus.frame_data;
                    if (bus.frame_last || end_idx) begin
                        err_d   = err_q | (bus.frame_last != end_idx);
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        state_d = PASS;
                        idx_d   = idx_q + 8'd1;
                    end
                end
                ACCUM: begin
                    sv_d = 1'b1;
                    sd_d = acc;
                    if (bus.frame_last) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        state_d = (idx_q == half_m1) ? STORE : ACCUM;
                        idx_d   = idx_q + 8'd1;
                    end
                end
                STORE: begin
                    tail_we = 1'b1;
                    if (bus.frame_last || end_idx) begin
                        err_d        = err_q | (bus.frame_last != end_idx);
                        tail_valid_d = 1'b1;
                        state_d      = IDLE;
                        idx_d        = '0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end

        if (state_q == FLUSH && out_free) begin
            sv_d = 1'b1;
            sd_d = tail_rd;
            if (idx_q == half_m1) begin
                tail_valid_d = 1'b0;
                state_d      = IDLE;
                idx_d        = '0;
            end else begin
                idx_d = idx_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            n256_q       <= 1'b0;
            ovl_q        <= 1'b0;
            tail_valid_q <= 1'b0;
            flush_pend_q <= 1'b0;
            err_q        <= 1'b0;
            sv_q         <= 1'b0;
            sd_q         <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            n256_q       <= n256_d;
            ovl_q        <= ovl_d;
            tail_valid_q <= tail_valid_d;
            flush_pend_q <= flush_pend_d;
            err_q        <= err_d;
            sv_q         <= sv_d;
            sd_q         <= sd_d;
        end
    end

    assign bus.frame_ready  = frame_ready;
    assign bus.sample_valid = sv_q;
    assign bus.sample_data  = sd_q;
    assign frame_error_o    = err_q;
    assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_overlap_add_deframer.sv
// Directed bench for overlap_add_deframer with an expected-sample queue.
module tb_overlap_add_deframer;
    import framer_pkg::*;

    logic clk = 1'b0;
    logic reset, use256, ovl, flush, frame_error, busy;

    overlap_add_deframer_if sif ();

    overlap_add_deframer #(
        .MAX_N (256)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .use_256_points_i      (use256),
        .overlap_half_window_i (ovl),
        .flush_i               (flush),
        .frame_error_o         (frame_error),
        .busy_o                (busy),
        .bus                   (sif.slave)
    );

    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         n_pop    = 0;
    sample_t    sb [$];
    logic       fire_seen = 1'b0;
    logic       bp_en     = 1'b0;
    logic [3:0] bp_pat    = 4'b1001;
    int         bp_k      = 0;
    logic       prev_stall = 1'b0;
    sample_t    prev_data  = '0;
    sample_t    sat_exp;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observes the stream mid-cycle, where inputs and outputs are settled.
    task automatic monitor();
        sample_t e;
        fire_seen = sif.frame_valid && sif.frame_ready;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold", {7'd0, sif.sample_valid, sif.sample_data}, {8'h01, prev_data});
            end
            if (bp_en) begin
                chk("frame_ready_rule", 16'(sif.frame_ready),
                    16'(!sif.sample_valid || sif.sample_ready));
            end
            if (sif.sample_valid && sif.sample_ready) begin
                n_assert++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_output: observed %0h expected none", sif.sample_data);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_data", 16'(sif.sample_data), 16'(e));
                end
                n_pop++;
            end
            prev_stall = sif.sample_valid && !sif.sample_ready;
            prev_data  = sif.sample_data;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (bp_en) begin
            sif.sample_ready = bp_pat[bp_k];
            bp_k = (bp_k + 1) % 4;
        end
    endtask

    task automatic send(input sample_t d, input logic l);
        int n = 0;
        sif.frame_valid = 1'b1;
        sif.frame_data  = d;
        sif.frame_last  = l;
        do begin
            cycle();
            n++;
        end while (!fire_seen && n < 1000);
        chk("send_accept", 16'(fire_seen), 16'd1);
        sif.frame_valid = 1'b0;
        sif.frame_last  = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            cycle();
            n++;
        end
        cycle();
        chk(tag, 16'(sb.size()), 16'd0);
    endtask

    initial begin
        int base;
        reset = 1'b1; use256 = 1'b0; ovl = 1'b0; flush = 1'b0;
        sif.frame_valid = 1'b0; sif.frame_data = '0; sif.frame_last = 1'b0;
        sif.sample_ready = 1'b1;
        repeat (3) cycle();
        chk("rst_sample_valid", 16'(sif.sample_valid), 16'd0);
        chk("rst_sample_data", 16'(sif.sample_data), 16'd0);
        chk("rst_frame_error", 16'(frame_error), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_frame_ready", 16'(sif.frame_ready), 16'd1);
        reset = 1'b0;
        cycle();

        // Pass-through, N=128, data = index, one-cycle latency.
        for (int i = 0; i < 128; i++) begin
            sb.push_back(sample_t'(i));
            send(sample_t'(i), i == 127);
            chk("pt_latency_valid", 16'(sif.sample_valid), 16'd1);
            chk("pt_latency_data", 16'(sif.sample_data), 16'(i));
        end
        drain("pt_drain");
        chk("pt_frame_error", 16'(frame_error), 16'd0);
        chk("pt_busy_end", 16'(busy), 16'd0);

        // Overlap-add N=128: A=10s, B=20s, then flush.
        ovl = 1'b1;
        for (int i = 0; i < 128; i++) begin
            if (i < 64) sb.push_back(8'd10);
            send(8'd10, i == 127);
        end
        for (int i = 0; i < 128; i++) begin
            if (i < 64) sb.push_back(8'd30);
            send(8'd20, i == 127);
        end
        for (int i = 0; i < 64; i++) sb.push_back(8'd20);
        pulse_flush();
        drain("ovl_drain");
        chk("ovl_busy_end", 16'(busy), 16'd0);
        chk("ovl_frame_error", 16'(frame_error), 16'd0);

        // Saturation / wrap, N=256, two frames of 200.
`ifdef DEFRAMER_SATURATE_EN
        sat_exp = 8'd255;
`else
        sat_exp = 8'd144;
`endif
        use256 = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 256; i++) begin
                if (i < 128) sb.push_back(f == 0 ? 8'd200 : sat_exp);
                send(8'd200, i == 255);
            end
        end
        drain("sat_drain");

        // Backpressure in pass-through; the mode change also discards the tail.
        use256 = 1'b0; ovl = 1'b0; bp_en = 1'b1; bp_k = 0;
        for (int i = 0; i < 128; i++) begin
            sb.push_back(sample_t'(255 - i));
            send(sample_t'(255 - i), i == 127);
        end
        drain("bp_drain");
        bp_en = 1'b0;
        sif.sample_ready = 1'b1;
        cycle();
        pulse_flush();
        repeat (3) cycle();
        chk("discarded_tail_flush_busy", 16'(busy), 16'd0);
        chk("discarded_tail_flush_valid", 16'(sif.sample_valid), 16'd0);

        // Framing error: frame_last at index 50, then a clean frame.
        for (int i = 0; i <= 50; i++) begin
            sb.push_back(sample_t'(i + 1));
            send(sample_t'(i + 1), i == 50);
        end
        chk("ferr_set", 16'(frame_error), 16'd1);
        chk("ferr_idle", 16'(busy), 16'd0);
        for (int i = 0; i < 128; i++) begin
            sb.push_back(sample_t'(2 * i));
            send(sample_t'(2 * i), i == 127);
        end
        chk("ferr_busy_end", 16'(busy), 16'd0);
        drain("ferr_drain");
        chk("ferr_sticky", 16'(frame_error), 16'd1);

        // Reset mid-flush after 10 tail outputs.
        ovl = 1'b1;
        for (int i = 0; i < 128; i++) begin
            if (i < 64) sb.push_back(sample_t'(i));
            send(sample_t'(i), i == 127);
        end
        drain("rf_frame_drain");
        base = n_pop;
        for (int i = 64; i < 128; i++) sb.push_back(sample_t'(i));
        pulse_flush();
        for (int n = 0; n < 200 && (n_pop - base) < 10; n++) cycle();
        chk("rf_ten_outputs", 16'(n_pop - base), 16'd10);
        reset = 1'b1;
        cycle();
        chk("rf_sample_valid", 16'(sif.sample_valid), 16'd0);
        chk("rf_busy", 16'(busy), 16'd0);
        chk("rf_frame_error_cleared", 16'(frame_error), 16'd0);
        sb.delete();
        reset = 1'b0;
        cycle();
        pulse_flush();
        repeat (4) cycle();
        chk("rf_flush_ignored_busy", 16'(busy), 16'd0);
        chk("rf_flush_ignored_valid", 16'(sif.sample_valid), 16'd0);
        chk("rf_no_extra_output", 16'(n_pop - base), 16'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
